tlp_src_arb: RTL

Packet-granular round-robin arbiter that shares one encapsulation datapath between several TLP source FIFOs. It sits between NUM_SRC first-word-fall-through TLP FIFOs and the encapsulator's single FIFO-read port. It presents itself to the encapsulator as one FIFO (rd_en/dout/empty). Grant is locked from arbitration until the word carrying tlast is consumed, so header and payload always come from one source.

---
 rtl/tlp_pkg.sv | 24 ++
 rtl/tlp_src_arb_if.sv | 42 ++++
 rtl/rr_pick.sv | 37 +++
 rtl/tlp_src_arb.sv | 120 ++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// Shared TLP FIFO word layout and arbiter state encoding for the tlp_src_arb slice.
// Optional statistics in the arbiter are enabled with TLP_SRC_ARB_STATS_EN.
package tlp_pkg;

  localparam int TLP_FIFO_W  = 74;
  localparam int TLP_KEEP_HI = 73;
  localparam int TLP_KEEP_LO = 66;
  localparam int TLP_DATA_HI = 65;
  localparam int TLP_DATA_LO = 2;
  localparam int TLP_LAST    = 1;
  localparam int TLP_USER    = 0;

  typedef logic [TLP_FIFO_W-1:0] tlp_word_t;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic logic tlp_is_last(tlp_word_t w);
    return w[TLP_LAST];
  endfunction

endpackage

// File: rtl/tlp_src_arb_if.sv
// Bundle of source-FIFO, encapsulator-FIFO and grant status signals for tlp_src_arb.
// Counter signals exist only when TLP_SRC_ARB_STATS_EN is defined.
interface tlp_src_arb_if #(
  parameter int NUM_SRC = 2
) ();
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                     src_en;
  logic [NUM_SRC-1:0]                     src_rd_en;
  tlp_pkg::tlp_word_t [NUM_SRC-1:0]       src_dout;
  logic [NUM_SRC-1:0]                     src_empty;
  logic                                   rd_en;
  tlp_pkg::tlp_word_t                     dout;
  logic                                   empty;
  logic                                   grant_valid;
  logic [SRC_W-1:0]                       grant_id;
`ifdef TLP_SRC_ARB_STATS_EN
  logic [NUM_SRC-1:0][31:0]               pkt_cnt;
  logic [31:0]                            stall_cnt;
`endif

`ifdef TLP_SRC_ARB_STATS_EN
  modport master (
    input  src_en, src_dout, src_empty, rd_en,
    output src_rd_en, dout, empty, grant_valid, grant_id, pkt_cnt, stall_cnt
  );
  modport slave (
    output src_en, src_dout, src_empty, rd_en,
    input  src_rd_en, dout, empty, grant_valid, grant_id, pkt_cnt, stall_cnt
  );
`else
  modport master (
    input  src_en, src_dout, src_empty, rd_en,
    output src_rd_en, dout, empty, grant_valid, grant_id
  );
  modport slave (
    output src_en, src_dout, src_empty, rd_en,
    input  src_rd_en, dout, empty, grant_valid, grant_id
  );
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational wrap-around priority search: first set req bit at or above ptr,
// otherwise the lowest set bit overall. Works for any NUM_REQ, not only powers of two.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  logic [NUM_REQ-1:0] w_hi_mask;
  logic [NUM_REQ-1:0] w_req_hi;
  logic [NUM_REQ-1:0] w_sel;
  logic [NUM_REQ-1:0] w_win;
  logic [ID_W-1:0]    w_id_acc [NUM_REQ+1];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign w_hi_mask[gi] = (ID_W'(gi) >= ptr);
  end

  assign w_req_hi = req & w_hi_mask;
  // Requests at/above the pointer take precedence; fall back to the wrapped-around set.
  assign w_sel    = (|w_req_hi) ? w_req_hi : req;
  assign w_id_acc[0] = '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_win
    localparam logic [NUM_REQ-1:0] LOWER = NUM_REQ'((1 << gi) - 1);
    assign w_win[gi]       = w_sel[gi] & ~(|(w_sel & LOWER));
    assign w_id_acc[gi+1]  = w_id_acc[gi] | (w_win[gi] ? ID_W'(gi) : '0);
  end

  assign gnt_id  = w_id_acc[NUM_REQ];
  assign gnt_any = |req;

endmodule

// File: rtl/tlp_src_arb.sv
// Packet-granular round-robin arbiter presenting several FWFT TLP FIFOs as one FIFO.
// Define TLP_SRC_ARB_STATS_EN to add per-source packet counters and a stall counter.
module tlp_src_arb
  import tlp_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic            clk156,
  input  logic            sys_rst_n,
  tlp_src_arb_if.master   bus
);

  localparam int SRC_W = $clog2(NUM_SRC);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  logic [SRC_W-1:0]    r_rr_ptr;
  logic [SRC_W-1:0]    r_grant_id;
  logic [SRC_W-1:0]    w_pick_id;
  logic                w_pick_any;
  logic [NUM_SRC-1:0]  w_eligible;
  logic [NUM_SRC-1:0]  w_src_rd_en;
  tlp_word_t           w_g_word;
  logic                w_g_empty;
  logic                w_rd_fwd;
  logic                w_release;
  tlp_word_t           w_dout;
  logic                w_empty;

  assign w_eligible = bus.src_en & ~bus.src_empty;

  rr_pick #(
    .NUM_REQ (NUM_SRC),
    .ID_W    (SRC_W)
  ) u_rr_pick (
    .req     (w_eligible),
    .ptr     (r_rr_ptr),
    .gnt_id  (w_pick_id),
    .gnt_any (w_pick_any)
  );

  assign w_g_word  = bus.src_dout[r_grant_id];
  assign w_g_empty = bus.src_empty[r_grant_id];

  always_comb begin
    w_state_next = r_state;
    w_dout       = '0;
    w_empty      = 1'b1;
    w_rd_fwd     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_pick_any) w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        w_dout    = w_g_word;
        w_empty   = w_g_empty;
        w_rd_fwd  = bus.rd_en & ~w_g_empty;
        // Lock is dropped only when the tlast word is actually popped.
        w_release = w_rd_fwd & tlp_is_last(w_g_word);
        if (w_release) w_state_next = ST_ARB;
      end
      default: w_state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_ARB;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_ARB && w_pick_any) r_grant_id <= w_pick_id;
      if (w_release) begin
        r_rr_ptr <= (r_grant_id == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant_id + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rd
    assign w_src_rd_en[gi] = w_rd_fwd & (r_grant_id == SRC_W'(gi));
  end

  assign bus.src_rd_en   = w_src_rd_en;
  assign bus.dout        = w_dout;
  assign bus.empty       = w_empty;
  assign bus.grant_valid = (r_state == ST_BUSY);
  assign bus.grant_id    = r_grant_id;

`ifdef TLP_SRC_ARB_STATS_EN
  logic [NUM_SRC-1:0][31:0] w_pkt_cnt;
  logic [31:0]              r_stall_cnt;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pkt
    logic [31:0] r_cnt;
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_cnt <= '0;
      end else if (w_release && r_grant_id == SRC_W'(gi)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign w_pkt_cnt[gi] = r_cnt;
  end

  // Saturates rather than wraps so a long stall never reads back as a short one.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == ST_BUSY && w_g_empty && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.pkt_cnt   = w_pkt_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
